// File: rtl/fitness_scorer.sv
// Bit-error fitness scorer: compares a candidate's four 16-bit outputs against
// targets, one sample per handshake, and accumulates the total bit-error count.
module fitness_scorer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] num_samples,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] y3,
  input  logic [15:0] y2,
  input  logic [15:0] y1,
  input  logic [15:0] y0,
  input  logic [15:0] e3,
  input  logic [15:0] e2,
  input  logic [15:0] e1,
  input  logic [15:0] e0,
  output logic        busy,
  output logic        done,
  output logic [21:0] score,
  output logic [15:0] samples_seen,
  output logic        perfect
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      state_q;
  logic [15:0] num_q;
  logic [15:0] seen_q;
  logic [21:0] score_q;
  logic [6:0]  err_q;
  logic        s1_valid_q;
  logic [6:0]  err_d;
  logic        accept_d;

  function automatic logic [4:0] popcnt16(input logic [15:0] v);
    logic [4:0] cnt;
    cnt = 5'd0;
    for (int i = 0; i < 16; i++) begin
      cnt = cnt + {4'd0, v[i]};
    end
    return cnt;
  endfunction

  // Per-sample error count and handshake decode
  always_comb begin
    accept_d = in_valid && (state_q == S_RUN);
    err_d    = {2'b00, popcnt16(y3 ^ e3)} + {2'b00, popcnt16(y2 ^ e2)}
             + {2'b00, popcnt16(y1 ^ e1)} + {2'b00, popcnt16(y0 ^ e0)};
  end

  // Control FSM, stage-1 error register and stage-2 accumulator
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      num_q      <= 16'd0;
      seen_q     <= 16'd0;
      score_q    <= 22'd0;
      err_q      <= 7'd0;
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= accept_d;
      if (accept_d) begin
        err_q <= err_d;
      end else begin
        err_q <= err_q;
      end
      // Worst-case total fits in 22 bits, so the add never wraps.
      if (s1_valid_q) begin
        score_q <= score_q + {15'd0, err_q};
      end else begin
        score_q <= score_q;
      end
      case (state_q)
        S_IDLE: begin
          if (start) begin
            num_q   <= num_samples;
            seen_q  <= 16'd0;
            score_q <= 22'd0;
            state_q <= (num_samples == 16'd0) ? S_DONE : S_RUN;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          if (accept_d) begin
            seen_q <= seen_q + 16'd1;
            if ((seen_q + 16'd1) == num_q) begin
              state_q <= S_DRAIN;
            end else begin
              state_q <= S_RUN;
            end
          end else begin
            state_q <= S_RUN;
          end
        end
        S_DRAIN: state_q <= S_DONE;
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready     = (state_q == S_RUN);
  assign busy         = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done         = (state_q == S_DONE);
  assign score        = score_q;
  assign samples_seen = seen_q;
  assign perfect      = done && (score_q == 22'd0);

endmodule

// File: tb/tb_fitness_scorer.sv
// Table-driven bench for fitness_scorer with a scoreboard of per-run results.
module tb_fitness_scorer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] num_samples;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] y3, y2, y1, y0, e3, e2, e1, e0;
  logic        busy, done, perfect;
  logic [21:0] score;
  logic [15:0] samples_seen;

  fitness_scorer dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready),
    .y3(y3), .y2(y2), .y1(y1), .y0(y0),
    .e3(e3), .e2(e2), .e1(e1), .e0(e0),
    .busy(busy), .done(done), .score(score),
    .samples_seen(samples_seen), .perfect(perfect)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         n;
    int         mode;   // 0 equal, 1 random, 2 all bits wrong, 3 two-sample 16+64 pattern
    logic [7:0] vmask;  // in_valid pattern, bit i used on loop cycle i mod 8
    bit         noise;  // hold start high during RUN/DRAIN/DONE
    int         exp_score; // -1: take the bench model's value
  } vec_t;

  typedef struct {
    logic [21:0] score;
    logic [15:0] seen;
  } exp_t;

  exp_t        exp_q[$];
  vec_t        tbl[7];
  logic [15:0] sy[16][4];
  logic [15:0] se[16][4];
  int          checks = 0;
  int          errors = 0;
  logic [21:0] last_score;
  logic [15:0] last_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding run.
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("score", {10'd0, score}, {10'd0, e.score});
        chk("samples_seen", {16'd0, samples_seen}, {16'd0, e.seen});
        chk("perfect", {31'd0, perfect}, {31'd0, (e.score == 22'd0)});
      end
    end
  end

  task automatic drive_sample(input int idx, input bit valid);
    if (valid) begin
      {y3, y2, y1, y0} = {sy[idx][3], sy[idx][2], sy[idx][1], sy[idx][0]};
      {e3, e2, e1, e0} = {se[idx][3], se[idx][2], se[idx][1], se[idx][0]};
    end else begin
      {y3, y2, y1, y0} = {$urandom, $urandom};
      {e3, e2, e1, e0} = {$urandom, $urandom};
    end
  endtask

  task automatic gen_samples(input int n, input int mode);
    logic [15:0] r;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 4; j++) begin
        r = 16'($urandom);
        case (mode)
          0:       begin sy[i][j] = r; se[i][j] = r; end
          1:       begin sy[i][j] = r; se[i][j] = 16'($urandom); end
          2:       begin sy[i][j] = 16'hFFFF; se[i][j] = 16'h0000; end
          default: begin
            if ((i == 1) || (j == 0)) begin
              sy[i][j] = 16'hFFFF; se[i][j] = 16'h0000;
            end else begin
              sy[i][j] = r; se[i][j] = r;
            end
          end
        endcase
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    int          idx;
    int          cyc;
    bit          acc;
    logic [21:0] model;
    exp_t        e;
    gen_samples(v.n, v.mode);
    model = 22'd0;
    for (int i = 0; i < v.n; i++) begin
      for (int j = 0; j < 4; j++) begin
        model = model + 22'($countones(sy[i][j] ^ se[i][j]));
      end
    end
    e.score = (v.exp_score >= 0) ? 22'(v.exp_score) : model;
    e.seen  = 16'(v.n);
    exp_q.push_back(e);
    last_score = e.score;
    last_seen  = e.seen;
    @(negedge clk);
    start = 1'b1;
    num_samples = 16'(v.n);
    @(negedge clk);
    start = v.noise;
    num_samples = 16'd9;
    if (v.n == 0) begin
      chk("zero_done", {31'd0, done}, 32'd1);
      chk("zero_in_ready", {31'd0, in_ready}, 32'd0);
      chk("zero_busy", {31'd0, busy}, 32'd0);
    end else begin
      idx = 0;
      cyc = 0;
      while ((idx < v.n) && (cyc < 64)) begin
        chk("in_ready_run", {31'd0, in_ready}, 32'd1);
        in_valid = v.vmask[cyc % 8];
        drive_sample(idx, in_valid);
        acc = in_valid && in_ready;
        @(negedge clk);
        if (acc) idx++;
        cyc++;
      end
      if (idx < v.n) chk("accept_timeout", 32'(idx), 32'(v.n));
      // DRAIN: a valid presented now must be ignored.
      in_valid = 1'b1;
      drive_sample(0, 1'b0);
      chk("drain_in_ready", {31'd0, in_ready}, 32'd0);
      chk("drain_busy", {31'd0, busy}, 32'd1);
      chk("drain_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      in_valid = 1'b0;
      chk("done_latency", {31'd0, done}, 32'd1);
      chk("done_busy", {31'd0, busy}, 32'd0);
      chk("done_in_ready", {31'd0, in_ready}, 32'd0);
    end
  endtask

  initial begin
    tbl[0] = '{n: 3,  mode: 0, vmask: 8'hFF,        noise: 1'b0, exp_score: 0};
    tbl[1] = '{n: 2,  mode: 3, vmask: 8'hFF,        noise: 1'b0, exp_score: 80};
    tbl[2] = '{n: 4,  mode: 1, vmask: 8'b0101_1001, noise: 1'b0, exp_score: -1};
    tbl[3] = '{n: 0,  mode: 1, vmask: 8'hFF,        noise: 1'b0, exp_score: 0};
    tbl[4] = '{n: 5,  mode: 1, vmask: 8'hFF,        noise: 1'b1, exp_score: -1};
    tbl[5] = '{n: 16, mode: 2, vmask: 8'b1110_1111, noise: 1'b0, exp_score: 1024};
    tbl[6] = '{n: 1,  mode: 1, vmask: 8'b0000_0100, noise: 1'b0, exp_score: -1};

    rst = 1'b1; start = 1'b0; num_samples = 16'd0; in_valid = 1'b0;
    drive_sample(0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b1; num_samples = 16'd4; in_valid = 1'b1;
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_score", {10'd0, score}, 32'd0);
    chk("rst_seen", {16'd0, samples_seen}, 32'd0);
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;

    for (int t = 0; t < 7; t++) run_vec(tbl[t]);

    // Results hold in IDLE until the next accepted start.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      start = 1'b0;
      in_valid = 1'b1;
      chk("hold_score", {10'd0, score}, {10'd0, last_score});
      chk("hold_seen", {16'd0, samples_seen}, {16'd0, last_seen});
    end
    in_valid = 1'b0;

    // Reset mid-run with a sample still in stage 1: run aborts, nothing added.
    gen_samples(5, 3);
    for (int i = 0; i < 5; i++) begin
      sy[i][0] = 16'hFFFF; se[i][0] = 16'h0000;
      for (int j = 1; j < 4; j++) se[i][j] = sy[i][j];
    end
    @(negedge clk);
    start = 1'b1; num_samples = 16'd5;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      drive_sample(i, 1'b1);
      @(negedge clk);
    end
    chk("pre_rst_score", {10'd0, score}, 32'd32);
    chk("pre_rst_seen", {16'd0, samples_seen}, 32'd3);
    drive_sample(3, 1'b1);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    chk("abort_score", {10'd0, score}, 32'd0);
    chk("abort_seen", {16'd0, samples_seen}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd0);
    for (int k = 0; k < 4; k++) @(negedge clk);

    run_vec(tbl[1]);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
